ex_md_arbiter: RTL and testbench

//  Shares one iterative multiply/divide unit between the two execute sub-pipes (sub0, sub1) of the

---
 rtl/ex_md_arbiter.sv | 153 +++++++++++++++
 tb/tb_ex_md_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_md_arbiter.sv
// Shares one iterative multiply/divide unit between execute sub-pipes sub0 and sub1.
// Grants by program order, sequences start/done, stalls requesters and drops flushed results.
module ex_md_arbiter #(
  parameter int unsigned DATA_WD  = 32,
  parameter int unsigned OP_WD    = 2,
  parameter int unsigned WDOG_MAX = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               req0_valid,
  input  logic               req0_first,
  input  logic [OP_WD-1:0]   req0_op,
  input  logic [DATA_WD-1:0] req0_src1,
  input  logic [DATA_WD-1:0] req0_src2,
  input  logic               req1_valid,
  input  logic               req1_first,
  input  logic [OP_WD-1:0]   req1_op,
  input  logic [DATA_WD-1:0] req1_src1,
  input  logic [DATA_WD-1:0] req1_src2,
  output logic               md_start,
  output logic [OP_WD-1:0]   md_op,
  output logic [DATA_WD-1:0] md_src1,
  output logic [DATA_WD-1:0] md_src2,
  input  logic               md_done,
  input  logic [DATA_WD-1:0] md_hi,
  input  logic [DATA_WD-1:0] md_lo,
  output logic               resp_valid,
  output logic               resp_id,
  output logic [DATA_WD-1:0] resp_hi,
  output logic [DATA_WD-1:0] resp_lo,
  output logic               stall0,
  output logic               stall1,
  output logic               md_err
);

  localparam int unsigned CNT_WD = $clog2(WDOG_MAX + 1);
  localparam logic [CNT_WD-1:0] WDOG_LIM = CNT_WD'(WDOG_MAX);

  typedef enum logic [2:0] {IDLE, START, BUSY, RESP, DRAIN} state_e;

  state_e             state_q, state_d;
  logic               md_start_q, md_start_d;
  logic [OP_WD-1:0]   op_q, op_d;
  logic [DATA_WD-1:0] src1_q, src1_d;
  logic [DATA_WD-1:0] src2_q, src2_d;
  logic               id_q, id_d;
  logic               resp_q, resp_d;
  logic [DATA_WD-1:0] hi_q, hi_d;
  logic [DATA_WD-1:0] lo_q, lo_d;
  logic [CNT_WD-1:0]  cnt_q, cnt_d;
  logic [CNT_WD-1:0]  cnt_inc;
  logic               err_q, err_d;
  logic               grant1;

  always_comb begin
    state_d    = state_q;
    md_start_d = 1'b0;
    op_d       = op_q;
    src1_d     = src1_q;
    src2_d     = src2_q;
    id_d       = id_q;
    resp_d     = 1'b0;
    hi_d       = hi_q;
    lo_d       = lo_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    cnt_inc    = cnt_q + CNT_WD'(1);
    // sub1 wins only when it alone is the older instruction, or sub0 is not requesting
    grant1     = req1_valid & (~req0_valid | (req1_first & ~req0_first));

    unique case (state_q)
      IDLE: begin
        if ((req0_valid | req1_valid) & ~flush) begin
          id_d       = grant1;
          op_d       = grant1 ? req1_op   : req0_op;
          src1_d     = grant1 ? req1_src1 : req0_src1;
          src2_d     = grant1 ? req1_src2 : req0_src2;
          md_start_d = 1'b1;
          state_d    = START;
        end
      end
      START: begin
        cnt_d   = '0;
        state_d = flush ? DRAIN : BUSY;
      end
      BUSY: begin
        if (md_done) begin
          if (flush) begin
            state_d = IDLE;
          end else begin
            hi_d    = md_hi;
            lo_d    = md_lo;
            resp_d  = 1'b1;
            state_d = RESP;
          end
        end else begin
          if (flush) state_d = DRAIN;
          if (cnt_q != WDOG_LIM) begin
            cnt_d = cnt_inc;
            if (cnt_inc == WDOG_LIM) err_d = 1'b1;
          end
        end
      end
      RESP:  state_d = IDLE;
      DRAIN: if (md_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      md_start_q <= 1'b0;
      op_q       <= '0;
      src1_q     <= '0;
      src2_q     <= '0;
      id_q       <= 1'b0;
      resp_q     <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      md_start_q <= md_start_d;
      op_q       <= op_d;
      src1_q     <= src1_d;
      src2_q     <= src2_d;
      id_q       <= id_d;
      resp_q     <= resp_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
    end
  end

  assign md_start = md_start_q;
  assign md_op    = op_q;
  assign md_src1  = src1_q;
  assign md_src2  = src2_q;
  // A flush arriving during the response cycle cancels the return
  assign resp_valid = resp_q & ~flush;
  assign resp_id    = id_q;
  assign resp_hi    = hi_q;
  assign resp_lo    = lo_q;
  assign md_err     = err_q;

  assign stall0 = req0_valid & ~(resp_valid & ~resp_id) & ~flush;
  assign stall1 = req1_valid & ~(resp_valid &  resp_id) & ~flush;

endmodule

// File: tb/tb_ex_md_arbiter.sv
// Directed bench for ex_md_arbiter: arbitration order, latency, flush/drain,
// watchdog error and asynchronous reset behaviour.
module tb_ex_md_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        req0_valid, req0_first;
  logic [1:0]  req0_op;
  logic [31:0] req0_src1, req0_src2;
  logic        req1_valid, req1_first;
  logic [1:0]  req1_op;
  logic [31:0] req1_src1, req1_src2;
  logic        md_start;
  logic [1:0]  md_op;
  logic [31:0] md_src1, md_src2;
  logic        md_done;
  logic [31:0] md_hi, md_lo;
  logic        resp_valid, resp_id;
  logic [31:0] resp_hi, resp_lo;
  logic        stall0, stall1, md_err;

  int tests = 0;
  int fails = 0;

  ex_md_arbiter #(.DATA_WD(32), .OP_WD(2), .WDOG_MAX(64)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .req0_valid(req0_valid), .req0_first(req0_first), .req0_op(req0_op),
    .req0_src1(req0_src1), .req0_src2(req0_src2),
    .req1_valid(req1_valid), .req1_first(req1_first), .req1_op(req1_op),
    .req1_src1(req1_src1), .req1_src2(req1_src2),
    .md_start(md_start), .md_op(md_op), .md_src1(md_src1), .md_src2(md_src2),
    .md_done(md_done), .md_hi(md_hi), .md_lo(md_lo),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_hi(resp_hi), .resp_lo(resp_lo),
    .stall0(stall0), .stall1(stall1), .md_err(md_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; flush = 1'b0;
    req0_valid = 1'b0; req0_first = 1'b0; req0_op = 2'd0; req0_src1 = '0; req0_src2 = '0;
    req1_valid = 1'b0; req1_first = 1'b0; req1_op = 2'd0; req1_src1 = '0; req1_src2 = '0;
    md_done = 1'b0; md_hi = '0; md_lo = '0;
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst_md_start", md_start, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_md_op", md_op, 0);
    chk("rst_md_src1", md_src1, 0);
    chk("rst_md_err", md_err, 0);
    chk("rst_stall0", stall0, 0);

    // Test 1: sub0 mult 3 x 0xFFFFFFFF, L=1
    tick();
    req0_valid = 1'b1; req0_op = 2'b00; req0_src1 = 32'h3; req0_src2 = 32'hFFFF_FFFF;
    #1;
    chk("t1_c0_md_start", md_start, 0);
    chk("t1_c0_stall0", stall0, 1);
    tick();
    chk("t1_c1_md_start", md_start, 1);
    chk("t1_c1_md_op", md_op, 0);
    chk("t1_c1_md_src1", md_src1, 32'h3);
    chk("t1_c1_md_src2", md_src2, 32'hFFFF_FFFF);
    tick();
    md_done = 1'b1; md_hi = 32'hFFFF_FFFF; md_lo = 32'hFFFF_FFFD;
    #1;
    chk("t1_c2_md_start", md_start, 0);
    chk("t1_c2_resp_valid", resp_valid, 0);
    tick();
    md_done = 1'b0;
    #1;
    chk("t1_c3_resp_valid", resp_valid, 1);
    chk("t1_c3_resp_id", resp_id, 0);
    chk("t1_c3_resp_hi", resp_hi, 32'hFFFF_FFFF);
    chk("t1_c3_resp_lo", resp_lo, 32'hFFFF_FFFD);
    chk("t1_c3_stall0", stall0, 0);
    req0_valid = 1'b0;
    tick();
    chk("t1_c4_resp_valid", resp_valid, 0);

    // Test 2: both request, sub1 older: divu 7/2 first, then sub0 mult 5 x 6
    req0_valid = 1'b1; req0_first = 1'b0; req0_op = 2'b00; req0_src1 = 32'd5; req0_src2 = 32'd6;
    req1_valid = 1'b1; req1_first = 1'b1; req1_op = 2'b11; req1_src1 = 32'd7; req1_src2 = 32'd2;
    tick();
    chk("t2_c1_md_start", md_start, 1);
    chk("t2_c1_md_op", md_op, 2'b11);
    chk("t2_c1_md_src1", md_src1, 32'd7);
    chk("t2_c1_stall0", stall0, 1);
    chk("t2_c1_stall1", stall1, 1);
    tick();
    md_done = 1'b1; md_hi = 32'd1; md_lo = 32'd3;
    tick();
    md_done = 1'b0;
    #1;
    chk("t2_c3_resp_valid", resp_valid, 1);
    chk("t2_c3_resp_id", resp_id, 1);
    chk("t2_c3_resp_hi", resp_hi, 32'd1);
    chk("t2_c3_resp_lo", resp_lo, 32'd3);
    chk("t2_c3_stall0", stall0, 1);
    chk("t2_c3_stall1", stall1, 0);
    req1_valid = 1'b0; req1_first = 1'b0;
    tick();
    chk("t2_c4_md_start", md_start, 0);
    chk("t2_c4_md_src1_held", md_src1, 32'd7);
    tick();
    chk("t2_c5_md_start", md_start, 1);
    chk("t2_c5_md_op", md_op, 2'b00);
    chk("t2_c5_md_src1", md_src1, 32'd5);
    tick();
    md_done = 1'b1; md_hi = 32'd0; md_lo = 32'd30;
    tick();
    md_done = 1'b0;
    #1;
    chk("t2_c7_resp_id", resp_id, 0);
    chk("t2_c7_resp_lo", resp_lo, 32'd30);
    req0_valid = 1'b0;
    tick();

    // Test 3: both request, neither first -> sub0 then sub1
    req0_valid = 1'b1; req0_op = 2'b01; req0_src1 = 32'd2; req0_src2 = 32'd3;
    req1_valid = 1'b1; req1_op = 2'b00; req1_src1 = 32'd4; req1_src2 = 32'd5;
    tick();
    chk("t3_c1_md_op", md_op, 2'b01);
    chk("t3_c1_md_src1", md_src1, 32'd2);
    tick();
    md_done = 1'b1; md_hi = 32'd0; md_lo = 32'd6;
    tick();
    md_done = 1'b0;
    #1;
    chk("t3_c3_resp_valid", resp_valid, 1);
    chk("t3_c3_resp_id", resp_id, 0);
    chk("t3_c3_stall1", stall1, 1);
    chk("t3_c3_md_start", md_start, 0);
    req0_valid = 1'b0;
    tick();
    chk("t3_c4_md_start", md_start, 0);
    tick();
    chk("t3_c5_md_start", md_start, 1);
    chk("t3_c5_md_src1", md_src1, 32'd4);
    tick();
    md_done = 1'b1; md_lo = 32'd20;
    tick();
    md_done = 1'b0;
    #1;
    chk("t3_c7_resp_valid", resp_valid, 1);
    chk("t3_c7_resp_id", resp_id, 1);
    chk("t3_c7_resp_lo", resp_lo, 32'd20);
    req1_valid = 1'b0;
    tick();

    // Test 4: flush two cycles into BUSY, L=10, then a fresh request
    req0_valid = 1'b1; req0_op = 2'b10; req0_src1 = 32'd100; req0_src2 = 32'd7;
    tick();
    chk("t4_c1_md_start", md_start, 1);
    tick();
    tick();
    flush = 1'b1; req0_valid = 1'b0;
    #1;
    chk("t4_c3_stall0", stall0, 0);
    tick();
    flush = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("t4_drain_resp_valid", resp_valid, 0);
    end
    md_done = 1'b1; md_hi = 32'd2; md_lo = 32'd14;
    tick();
    md_done = 1'b0;
    #1;
    chk("t4_c12_resp_valid", resp_valid, 0);
    chk("t4_c12_md_src1_held", md_src1, 32'd100);
    req1_valid = 1'b1; req1_first = 1'b0; req1_op = 2'b00; req1_src1 = 32'h10; req1_src2 = 32'h10;
    tick();
    chk("t4_c13_md_start", md_start, 1);
    chk("t4_c13_md_src1", md_src1, 32'h10);
    tick();
    md_done = 1'b1; md_hi = 32'd0; md_lo = 32'h100;
    tick();
    md_done = 1'b0;
    #1;
    chk("t4_c15_resp_valid", resp_valid, 1);
    chk("t4_c15_resp_id", resp_id, 1);
    chk("t4_c15_resp_lo", resp_lo, 32'h100);
    req1_valid = 1'b0;
    tick();

    // Test 5: md_done withheld -> watchdog error, cleared by async reset
    req0_valid = 1'b1; req0_op = 2'b00; req0_src1 = 32'd1; req0_src2 = 32'd1;
    tick();
    chk("t5_c1_md_start", md_start, 1);
    repeat (60) tick();
    chk("t5_early_md_err", md_err, 0);
    repeat (10) tick();
    chk("t5_md_err_set", md_err, 1);
    chk("t5_stall0", stall0, 1);
    chk("t5_resp_valid", resp_valid, 0);
    tick();
    chk("t5_md_err_sticky", md_err, 1);
    reset = 1'b1;
    #1;
    chk("t5_rst_md_err", md_err, 0);
    chk("t5_rst_stall0_req", stall0, 1);
    req0_valid = 1'b0;
    #1;
    chk("t5_rst_stall0_noreq", stall0, 0);
    tick();
    reset = 1'b0;
    tick();
    chk("t5_after_md_start", md_start, 0);

    // Test 6: reset mid-BUSY, then a late md_done
    req0_valid = 1'b1; req0_op = 2'b01; req0_src1 = 32'd9; req0_src2 = 32'd9;
    tick();
    chk("t6_c1_md_start", md_start, 1);
    tick();
    tick();
    reset = 1'b1; req0_valid = 1'b0;
    #1;
    chk("t6_rst_md_src1", md_src1, 0);
    tick();
    reset = 1'b0;
    tick();
    md_done = 1'b1; md_hi = 32'hAA; md_lo = 32'hBB;
    tick();
    md_done = 1'b0;
    #1;
    chk("t6_late_resp_valid", resp_valid, 0);
    chk("t6_late_md_start", md_start, 0);
    tick();
    chk("t6_late2_resp_valid", resp_valid, 0);
    chk("t6_late2_resp_lo", resp_lo, 0);
    chk("t6_md_err", md_err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
